fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage sitting directly upstream of the multicycle control FSM. Owns the program counter and instruction register, drives a ready/valid instruction-memory port that tolerates variable latency, resolves bne/beq and jump/jal PC updates from the control strobes, and presents `Opcode` and the immediate field to control and datapath. While an instruction read is outstanding it raises `fetch_stall`, and control holds in Fetch.

## Interface
Parameters:
- `ADDR_W`, 16: PC and instruction-address width.
- `INSTR_W`, 16: instruction width. Opcode is `IR[15:10]` and immediate is `IR[9:0]`.
- `RESET_PC`, 0: PC value after reset.
- `TIMEOUT`, 15: maximum number of wait cycles for `imem_ready` before the fetch is abandoned.

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `PCWrite`, in, 2: unconditional PC write strobe from control. Nonzero means write.
- `PCSrc`, in, 2: PC source. 0 selects `ALUResult`, 1 selects the jump target, 2 selects `BranchTarget`, 3 is reserved and holds the PC.
- `Branch`, in, 2: conditional-branch strobe. Nonzero means evaluate.
- `BneOrBeq`, in, 2: 1 selects beq, 0 selects bne.
- `IRWrite`, in, 1: request to fetch the instruction at PC into IR.
- `ALUResult`, in, ADDR_W: sequential PC (PC+2) from the datapath ALU.
- `ALUZero`, in, 1: ALU zero flag.
- `BranchTarget`, in, ADDR_W: branch target from the datapath ALUOut register.
- `imem_req`, out, 1: read request.
- `imem_addr`, out, ADDR_W: read address. Always equals PC.
- `imem_rdata`, in, INSTR_W: read data. Valid when `imem_ready` is high.
- `imem_ready`, in, 1: read completes this cycle.
- `fetch_stall`, out, 1: control must hold its current state.
- `fetch_err`, out, 1: sticky flag, set when a fetch times out.
- `PC`, out, ADDR_W: current program counter.
- `Opcode`, out, 6: `IR[15:10]`.
- `Imm`, out, 10: `IR[9:0]`.

## Operation
FSM states:
- **IDLE**
  - If `IRWrite` is high, assert `imem_req`.
  - If `imem_ready` is also high in the same cycle, the fetch completes and the FSM stays in IDLE.
  - Otherwise move to WAIT and clear the timeout counter.
- **WAIT**
  - `imem_req` is held high and `imem_addr` is held stable. The counter increments each cycle.
  - On `imem_ready`, the fetch completes and the FSM returns to IDLE.
  - If the counter reaches `TIMEOUT` first, the fetch is abandoned and the FSM returns to IDLE (see fetch completion).
- **Fetch completion**
  - On `imem_ready`: IR <= `imem_rdata`.
  - On timeout: IR <= 0 and `fetch_err` <= 1. Opcode 0 decodes to the control FSM's wrong-opcode path, which returns to Fetch.

Combinational outputs:
- `imem_req` = (IDLE and `IRWrite`) or WAIT.
- `fetch_stall` = `imem_req` and not `imem_ready` and not timeout-this-cycle.

PC update rules, evaluated every cycle:
- **Unconditional write.** When `PCWrite` is nonzero and `fetch_stall` is 0, PC <= the source selected by `PCSrc`.
  - Gating on `fetch_stall` means the PC+2 write in Fetch lands only on the completion cycle. `ALUResult` stays stable because PC has not changed.
- **Jump target.** {PC[ADDR_W-1:11], `Imm`, 1'b0}, computed from the current IR.
- **Conditional branch.** When `Branch` is nonzero, PC <= `BranchTarget` if taken.
  - Taken = (`BneOrBeq`==1 and `ALUZero`) or (`BneOrBeq`==0 and not `ALUZero`).
  - `PCSrc` is ignored for branches.
- **Simultaneous strobes.** If `PCWrite` and `Branch` are both nonzero, `PCWrite` wins.
- **Reserved source.** `PCSrc`=3 leaves PC unchanged.
- **Width.** All PC arithmetic is modulo 2^ADDR_W. The value 0xFFFE + 2 wraps to 0x0000, and no flag is raised.

## Timing
- **Reset values:** PC=`RESET_PC`, IR=0 (so `Opcode`=0 and `Imm`=0), `imem_req`=0, `fetch_stall`=0, `fetch_err`=0, FSM=IDLE, counter=0.
- **Reset mid-WAIT:** the outstanding request is dropped in the next cycle. Any `imem_ready` arriving in the reset cycle is ignored.
- **Fetch latency:** IR and PC update at the edge ending the cycle in which `imem_ready` is high.
  - Zero-wait memory: 1 cycle, no stall.
  - Memory with N wait states: `fetch_stall` is high for N cycles.
- **Data visibility:** `Opcode` and `Imm` are registered and are valid in Decode, the cycle after completion.
- **Jump and branch updates:** take effect at the next edge and do not touch `imem_*`.
- **`fetch_err`:** cleared only by `Reset`.
- **`IRWrite` in WAIT:** ignored. A new request is accepted only in IDLE.

## Structure
- Shared package `acc_pkg` holds:
  - the `PCSrc` encodings (`PCSRC_ALU`, `PCSRC_JUMP`, `PCSRC_BRANCH`);
  - the opcode field positions (`OPC_HI`=15, `OPC_LO`=10, `IMM_W`=10);
  - the fetch-state enum.
- The control FSM imports the same package and gains a `fetch_stall` hold input.
- One sub-module is natural: `branch_resolve`, purely combinational. Its inputs are `Branch`, `BneOrBeq`, `ALUZero`, `PCWrite`, `PCSrc`, and `fetch_stall`. Its output is `pc_we` and the PC mux select.

## Test plan
- **Zero-wait fetch.** Reset with `RESET_PC`=0, `imem_ready` tied high, `imem_rdata`=0x3C05, `IRWrite`=1, `PCWrite`=1, `PCSrc`=0, `ALUResult`=2 -> after one edge: PC=2, `Opcode`=0x0F, `Imm`=0x005, `fetch_stall` never high.
- **Three wait states.** `imem_ready` delayed three cycles -> `fetch_stall` high for exactly 3 cycles, `imem_addr` stable at the old PC, PC unchanged until the completion edge, then PC=`ALUResult`.
- **Branches.**
  - `Branch`=1, `BneOrBeq`=1, `ALUZero`=1, `BranchTarget`=0x0040 -> PC=0x0040.
  - Same with `ALUZero`=0 -> PC unchanged.
  - `BneOrBeq`=0, `ALUZero`=0 -> PC=0x0040.
- **Jump.** PC=0xA802, IR `Imm`=0x155, `PCWrite`=1, `PCSrc`=1 -> PC=0xAAAA.
- **Timeout.** `imem_ready` never rises -> after 15 wait cycles: IR=0, `fetch_err`=1, FSM=IDLE, `fetch_stall` low. `fetch_err` stays 1 across later successful fetches.
- **Reset mid-WAIT.** Assert `Reset` on wait cycle 2 -> the next cycle shows `imem_req`=0, PC=`RESET_PC`, IR=0, `fetch_err`=0. A fresh `IRWrite` then fetches from `RESET_PC`.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the fetch stage and the multicycle control FSM:
// PC source encodings, instruction field positions and the fetch-state enum.
package acc_pkg;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_JUMP   = 2'd1,
        PCSRC_BRANCH = 2'd2,
        PCSRC_HOLD   = 2'd3
    } pc_src_t;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 10;
    localparam int IMM_W  = 10;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_t;

    // BneOrBeq==1 is beq, 0 is bne; other encodings never take the branch.
    function automatic logic branch_taken(input logic [1:0] bne_or_beq, input logic alu_zero);
        return ((bne_or_beq == 2'd1) && alu_zero) || ((bne_or_beq == 2'd0) && !alu_zero);
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Decides whether the PC is written this cycle and which source feeds it.
// An unconditional write always outranks a branch, even while it is held off by a stall.
module branch_resolve
    import acc_pkg::*;
(
    input  logic [1:0] Branch,
    input  logic [1:0] BneOrBeq,
    input  logic       ALUZero,
    input  logic [1:0] PCWrite,
    input  logic [1:0] PCSrc,
    input  logic       fetch_stall,
    output logic       pc_we,
    output pc_src_t    pc_sel
);

    always_comb begin
        pc_we  = 1'b0;
        pc_sel = PCSRC_ALU;
        if (|PCWrite) begin
            if (!fetch_stall && (PCSrc != PCSRC_HOLD)) begin
                pc_we  = 1'b1;
                pc_sel = pc_src_t'(PCSrc);
            end
        end else if ((|Branch) && branch_taken(BneOrBeq, ALUZero)) begin
            pc_we  = 1'b1;
            pc_sel = PCSRC_BRANCH;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, runs a variable-latency imem port
// with a bounded wait, and applies jump/branch/sequential PC updates.
module fetch_unit
    import acc_pkg::*;
#(
    parameter int               ADDR_W   = 16,
    parameter int               INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int               TIMEOUT  = 15
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [1:0]         PCWrite,
    input  logic [1:0]         PCSrc,
    input  logic [1:0]         Branch,
    input  logic [1:0]         BneOrBeq,
    input  logic               IRWrite,
    input  logic [ADDR_W-1:0]  ALUResult,
    input  logic               ALUZero,
    input  logic [ADDR_W-1:0]  BranchTarget,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic               fetch_stall,
    output logic               fetch_err,
    output logic [ADDR_W-1:0]  PC,
    output logic [5:0]         Opcode,
    output logic [IMM_W-1:0]   Imm
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_t        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                err_q, err_d;
    logic                fetch_done;
    logic                timeout_now;
    logic                pc_we;
    pc_src_t             pc_sel;
    logic [ADDR_W-1:0]   jump_target;

    // The request cycle plus TIMEOUT-1 WAIT cycles may stall; the next WAIT
    // cycle is the last chance for imem_ready before the fetch is abandoned.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        imem_req    = 1'b0;
        fetch_done  = 1'b0;
        timeout_now = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (IRWrite) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        fetch_done = 1'b1;
                    end else begin
                        state_d = FETCH_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            FETCH_WAIT: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    fetch_done = 1'b1;
                    state_d    = FETCH_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_now = 1'b1;
                    state_d     = FETCH_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_comb begin
        ir_d  = ir_q;
        err_d = err_q;
        if (fetch_done) begin
            ir_d = imem_rdata;
        end else if (timeout_now) begin
            ir_d  = '0;
            err_d = 1'b1;
        end
    end

    assign fetch_stall = imem_req && !imem_ready && !timeout_now;

    branch_resolve u_branch_resolve (
        .Branch      (Branch),
        .BneOrBeq    (BneOrBeq),
        .ALUZero     (ALUZero),
        .PCWrite     (PCWrite),
        .PCSrc       (PCSrc),
        .fetch_stall (fetch_stall),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel)
    );

    assign jump_target = {pc_q[ADDR_W-1:IMM_W+1], Imm, 1'b0};

    always_comb begin
        pc_d = pc_q;
        if (pc_we) begin
            case (pc_sel)
                PCSRC_ALU:    pc_d = ALUResult;
                PCSRC_JUMP:   pc_d = jump_target;
                PCSRC_BRANCH: pc_d = BranchTarget;
                default:      pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= FETCH_IDLE;
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

    assign imem_addr = pc_q;
    assign PC        = pc_q;
    assign fetch_err = err_q;
    assign Opcode    = ir_q[OPC_HI:OPC_LO];
    assign Imm       = ir_q[IMM_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a vector table for single-cycle behaviour
// plus scripted wait-state, timeout and mid-wait reset sequences.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [1:0]  PCWrite, PCSrc, Branch, BneOrBeq;
    logic        IRWrite, ALUZero, imem_ready;
    logic [15:0] ALUResult, BranchTarget, imem_rdata;
    logic        imem_req, fetch_stall, fetch_err;
    logic [15:0] imem_addr, PC;
    logic [5:0]  Opcode;
    logic [9:0]  Imm;

    always #5 CLK = ~CLK;

    fetch_unit #(
        .ADDR_W   (16),
        .INSTR_W  (16),
        .RESET_PC (16'h0000),
        .TIMEOUT  (15)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .PCWrite      (PCWrite),
        .PCSrc        (PCSrc),
        .Branch       (Branch),
        .BneOrBeq     (BneOrBeq),
        .IRWrite      (IRWrite),
        .ALUResult    (ALUResult),
        .ALUZero      (ALUZero),
        .BranchTarget (BranchTarget),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .fetch_stall  (fetch_stall),
        .fetch_err    (fetch_err),
        .PC           (PC),
        .Opcode       (Opcode),
        .Imm          (Imm)
    );

    typedef struct {
        logic        rst;
        logic        irw;
        logic [1:0]  pcw;
        logic [1:0]  src;
        logic [1:0]  br;
        logic [1:0]  bob;
        logic        zero;
        logic        rdy;
        logic [15:0] alu;
        logic [15:0] bt;
        logic [15:0] rdata;
        logic        expReq;
        logic        expStall;
        logic [15:0] expAddr;
        logic [15:0] expPc;
        logic [5:0]  expOpc;
        logic [9:0]  expImm;
        logic        expErr;
    } vec_t;

    int   testsRun    = 0;
    int   testsFailed = 0;
    vec_t expQ[$];

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check combinational outputs mid-cycle,
    // queue the post-edge expectations and advance past the edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        Reset        = v.rst;
        IRWrite      = v.irw;
        PCWrite      = v.pcw;
        PCSrc        = v.src;
        Branch       = v.br;
        BneOrBeq     = v.bob;
        ALUZero      = v.zero;
        imem_ready   = v.rdy;
        ALUResult    = v.alu;
        BranchTarget = v.bt;
        imem_rdata   = v.rdata;
        expQ.push_back(v);
        #3;
        checkField({tag, " imem_req"}, 32'(imem_req), 32'(v.expReq));
        checkField({tag, " fetch_stall"}, 32'(fetch_stall), 32'(v.expStall));
        checkField({tag, " imem_addr"}, 32'(imem_addr), 32'(v.expAddr));
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        testsRun++;
        if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = expQ.pop_front();
            checkField({tag, " PC"}, 32'(PC), 32'(e.expPc));
            checkField({tag, " Opcode"}, 32'(Opcode), 32'(e.expOpc));
            checkField({tag, " Imm"}, 32'(Imm), 32'(e.expImm));
            checkField({tag, " fetch_err"}, 32'(fetch_err), 32'(e.expErr));
        end
    endtask

    task automatic runCycle(input vec_t v, input string tag);
        applyStimulus(v, tag);
        checkOutput(tag);
    endtask

    vec_t tbl[13];

    initial begin
        vec_t v;

        //          rst   irw   pcw   src   br    bob   zero  rdy   alu       bt        rdata     req   stall addr      pc        opc    imm     err
        tbl[0]  = '{1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 16'h0002, 16'h0000, 16'h3C05, 1'b1, 1'b0, 16'h0000, 16'h0002, 6'h0F, 10'h005, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd1, 1'b1, 1'b0, 16'h0000, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h0040, 6'h0F, 10'h005, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0, 16'h0000, 16'h0080, 16'h0000, 1'b0, 1'b0, 16'h0040, 16'h0040, 6'h0F, 10'h005, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0080, 16'h0000, 1'b0, 1'b0, 16'h0040, 16'h0080, 6'h0F, 10'h005, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 16'h0000, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0080, 16'h0080, 6'h0F, 10'h005, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 2'd1, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 16'h0080, 16'h0080, 6'h0F, 10'h005, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 2'd1, 2'd0, 2'd1, 2'd1, 1'b1, 1'b0, 16'h0200, 16'h0300, 16'h0000, 1'b0, 1'b0, 16'h0080, 16'h0200, 6'h0F, 10'h005, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 2'd2, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0400, 16'h0000, 1'b0, 1'b0, 16'h0200, 16'h0400, 6'h0F, 10'h005, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0400, 16'hFFFE, 6'h0F, 10'h005, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hA955, 1'b1, 1'b0, 16'hFFFE, 16'h0000, 6'h2A, 10'h155, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 16'hA802, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hA802, 6'h2A, 10'h155, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hA802, 16'hAAAA, 6'h2A, 10'h155, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 16'hAAAA, 16'hAAAA, 6'h2A, 10'h155, 1'b0};

        // Initial reset: hold for two edges, then check the reset state.
        Reset = 1'b1; IRWrite = 1'b0; PCWrite = 2'd0; PCSrc = 2'd0; Branch = 2'd0;
        BneOrBeq = 2'd0; ALUZero = 1'b0; imem_ready = 1'b0; ALUResult = '0;
        BranchTarget = '0; imem_rdata = '0;
        repeat (2) @(posedge CLK);
        #1;
        v = '{1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000,
              1'b0, 1'b0, 16'h0000, 16'h0000, 6'h00, 10'h000, 1'b0};
        runCycle(v, "reset");

        for (int i = 0; i < 13; i++) begin
            runCycle(tbl[i], $sformatf("vec%0d", i));
        end

        // Three wait states; IRWrite stays high in WAIT and must be ignored.
        v = '{1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 16'hAAAC, 16'h0000, 16'h0000,
              1'b1, 1'b1, 16'hAAAA, 16'hAAAA, 6'h2A, 10'h155, 1'b0};
        for (int i = 0; i < 3; i++) runCycle(v, $sformatf("wait3 stall%0d", i));
        v.rdy = 1'b1; v.rdata = 16'h0C21; v.expStall = 1'b0;
        v.expPc = 16'hAAAC; v.expOpc = 6'h03; v.expImm = 10'h021;
        runCycle(v, "wait3 done");
        v = '{1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000,
              1'b0, 1'b0, 16'hAAAC, 16'hAAAC, 6'h03, 10'h021, 1'b0};
        runCycle(v, "wait3 idle");

        // Timeout: 15 stall cycles, then the abandon cycle with stall low.
        v = '{1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000,
              1'b1, 1'b1, 16'hAAAC, 16'hAAAC, 6'h03, 10'h021, 1'b0};
        runCycle(v, "tmo req");
        v.irw = 1'b0;
        for (int i = 0; i < 14; i++) runCycle(v, $sformatf("tmo wait%0d", i));
        v.expStall = 1'b0; v.expOpc = 6'h00; v.expImm = 10'h000; v.expErr = 1'b1;
        runCycle(v, "tmo abandon");
        v.expReq = 1'b0;
        runCycle(v, "tmo idle");
        v = '{1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 16'hAAAE, 16'h0000, 16'h1403,
              1'b1, 1'b0, 16'hAAAC, 16'hAAAE, 6'h05, 10'h003, 1'b1};
        runCycle(v, "tmo sticky");

        // Reset on the second wait cycle, with a stray imem_ready that must be ignored.
        v = '{1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 16'hAAB0, 16'h0000, 16'h0000,
              1'b1, 1'b1, 16'hAAAE, 16'hAAAE, 6'h05, 10'h003, 1'b1};
        runCycle(v, "rstw req");
        v.irw = 1'b0;
        runCycle(v, "rstw wait1");
        v.rst = 1'b1; v.rdy = 1'b1; v.rdata = 16'hFFFF; v.alu = 16'hFFFF; v.expStall = 1'b0;
        v.expPc = 16'h0000; v.expOpc = 6'h00; v.expImm = 10'h000; v.expErr = 1'b0;
        runCycle(v, "rstw reset");
        v = '{1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000,
              1'b0, 1'b0, 16'h0000, 16'h0000, 6'h00, 10'h000, 1'b0};
        runCycle(v, "rstw idle");
        v = '{1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 16'h0002, 16'h0000, 16'h0810,
              1'b1, 1'b0, 16'h0000, 16'h0002, 6'h02, 10'h010, 1'b0};
        runCycle(v, "rstw refetch");

        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard drain: got %0d entries, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
